sc_et_sched: RTL
================

SC_ET_SCHED -- requirements
Module: sc_et_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- WIDTH, 8, LFSR and comparator width.
- NUM_INPUTS, 2, number of stochastic operands.
- LFSR_POLY, LFSR_8_POLYS[0], feedback polynomial.
- START_STATE, 1, LFSR seed.
- ET_MIN_LOG, 2, log2 of the first early-termination checkpoint.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, job request.
- in_ready, out, 1, scheduler idle and accepting.
- bxs, in, NUM_INPUTS*WIDTH, packed binary operands; operand i is in bits [i*WIDTH +: WIDTH].
- et_en, in, 1, early termination enable.
- et_tol, in, WIDTH, termination tolerance.
- abort, in, 1, cancel the running job.
- z_valid, out, 1, stream bit valid.
- z, out, 1, product bitstream bit.
- out_valid, out, 1, result valid.
- out_ready, in, 1, result consumed.
- result, out, WIDTH, scaled ones-count.
- out_len, out, WIDTH, cycles used.
- out_early, out, 1, job ended at a checkpoint.

Function
REQ-003 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-004 IDLE SHALL assert in_ready=1, and in_ready SHALL be 0 in every other state.
REQ-005 IDLE with in_valid=1 SHALL latch bxs, et_en and et_tol, load LFSR state=START_STATE, clear cnt and n, and move to RUN on the next cycle.
REQ-006 Every RUN cycle SHALL step one shared LFSR (state <= next state), and for each i SHALL compute x_i = next_state < bx_i.
REQ-007 Every RUN cycle SHALL compute z = AND of all x_i, assert z_valid=1, and update cnt += z and n += 1.
REQ-008 Checkpoint rule: when the updated n = 2^k with k >= ET_MIN_LOG-1, the scheduler SHALL store the updated cnt in prev_cnt.
REQ-009 Early termination: when et_en=1, updated n = 2^k, ET_MIN_LOG <= k <= WIDTH-1, and |cnt - 2*prev_cnt_(2^(k-1))| <= et_tol, the scheduler SHALL terminate.
- On this termination: result = min(cnt << (WIDTH-k), 2^WIDTH-1), out_early=1.
REQ-010 Full-period termination: when the updated n = 2^WIDTH-1, the scheduler SHALL terminate with result=cnt and out_early=0.
REQ-011 On termination the scheduler SHALL set out_len=n (updated value) and move to DONE on the next cycle.
REQ-012 DONE SHALL hold out_valid=1 with result, out_len and out_early stable until out_ready=1, then return to IDLE on the next cycle.
- out_valid SHALL be registered.
- The latency from acceptance to out_valid SHALL be out_len+1 cycles.
REQ-013 abort=1 in RUN SHALL return the FSM to IDLE next cycle with no out_valid pulse.
- abort SHALL take priority over a same-cycle termination.
- abort SHALL be ignored in IDLE and DONE.
REQ-014 in_valid in RUN or DONE SHALL be ignored (not queued).
REQ-015 Outside RUN, z_valid and z SHALL be 0.
- cnt SHALL be WIDTH bits wide, with intermediate compares WIDTH+1 bits wide.
- No signal SHALL wrap.

Reset
REQ-016 rst=1 SHALL asynchronously force: FSM=IDLE, LFSR=START_STATE, cnt=n=prev_cnt=0, in_ready=1 after release, out_valid=0, z_valid=0, z=0, result=0, out_len=0, out_early=0.
REQ-017 rst during RUN or DONE SHALL discard the job, and no result SHALL appear afterward.

Structure
REQ-018 The FSM state enum and the ET_MIN_LOG default SHALL live in a shared package sc_sched_pkg.
- The polynomials SHALL come from lfsr_polys_pkg.
REQ-019 The block SHALL instantiate exactly one existing combinational lfsr step module (DATA_WIDTH=1), with all remaining logic local.

Verification (WIDTH=8, NUM_INPUTS=2, ET_MIN_LOG=2)
REQ-020 bxs={0,0}, et_en=1, et_tol=0 -> early exit at n=4: result=0, out_len=4, out_early=1, out_valid 5 cycles after accept.
REQ-021 bxs={255,255}, et_en=0 -> 255 RUN cycles: result=254, out_len=255, out_early=0.
REQ-022 bxs={128,0}, et_en=0 -> z=0 all cycles: result=0, out_len=255.
REQ-023 Completed job with out_ready held 0 for 10 cycles -> out_valid, result and out_len stable, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-024 abort asserted at RUN cycle 20, and separately rst asserted at RUN cycle 20 -> no out_valid, in_ready=1 next cycle, LFSR reseeded to START_STATE.
REQ-025 Back-to-back jobs with identical bxs -> identical z sequences and identical results.

Source files
------------

// File: rtl/lfsr_polys_pkg.sv
// Feedback polynomial tables for the Galois LFSR step.
// LFSR_8_POLYS: maximal-length 8-bit right-shift Galois masks.
package lfsr_polys_pkg;

  localparam logic [7:0] LFSR_8_POLYS [0:3] = '{
    8'hB8, 8'hB4, 8'hB2, 8'hE1
  };

endpackage

// File: rtl/sc_sched_pkg.sv
// Shared types for the stochastic early-termination scheduler.
// Holds the FSM state enum and the default first checkpoint log2.
package sc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } sched_state_e;

  localparam int ET_MIN_LOG_DEF = 2;

endpackage

// File: rtl/lfsr_step.sv
// Combinational Galois LFSR step, DATA_WIDTH shifts per call.
// Ports: state_i current state, state_o advanced state.
module lfsr_step
  import lfsr_polys_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = LFSR_8_POLYS[0],
  parameter int               DATA_WIDTH = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] s;

  always_comb begin
    s = state_i;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    end
    state_o = s;
  end

endmodule

// File: rtl/sc_et_sched.sv
// Stochastic AND-product scheduler with early termination.
// Ports: in_valid/in_ready job handshake (bxs, et_en, et_tol),
// abort cancel, z_valid/z stream bit, out_valid/out_ready result
// handshake (result, out_len, out_early).
module sc_et_sched
  import sc_sched_pkg::*;
  import lfsr_polys_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NUM_INPUTS  = 2,
  parameter logic [WIDTH-1:0] LFSR_POLY   = LFSR_8_POLYS[0],
  parameter logic [WIDTH-1:0] START_STATE = WIDTH'(1),
  parameter int               ET_MIN_LOG  = ET_MIN_LOG_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0] bxs,
  input  logic                        et_en,
  input  logic [WIDTH-1:0]            et_tol,
  input  logic                        abort,
  output logic                        z_valid,
  output logic                        z,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            result,
  output logic [WIDTH-1:0]            out_len,
  output logic                        out_early
);

  sched_state_e state_q, state_d;

  logic [NUM_INPUTS*WIDTH-1:0] bx_q, bx_d;
  logic                        et_q, et_d;
  logic [WIDTH-1:0]            tol_q, tol_d;
  logic [WIDTH-1:0]            lfsr_q, lfsr_d, lfsr_nx;
  logic [WIDTH-1:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]            n_q, n_d;
  logic [WIDTH-1:0]            prev_q, prev_d;
  logic [WIDTH-1:0]            res_q, res_d;
  logic [WIDTH-1:0]            len_q, len_d;
  logic                        early_q, early_d;
  logic                        ov_q, ov_d;

  logic [NUM_INPUTS-1:0] x;
  logic                  z_run;
  logic [WIDTH-1:0]      cnt_nx, n_nx;
  logic [WIDTH:0]        cnt_w, twice, adiff, sh;
  logic                  close, ckpt, et_hit, full;
  logic [WIDTH-1:0]      et_res;

  lfsr_step #(
    .WIDTH      (WIDTH),
    .POLY       (LFSR_POLY),
    .DATA_WIDTH (1)
  ) u_lfsr (
    .state_i (lfsr_q),
    .state_o (lfsr_nx)
  );

  always_comb begin
    x = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      x[i] = lfsr_nx < bx_q[i*WIDTH +: WIDTH];
    end
    z_run  = &x;
    cnt_nx = cnt_q + WIDTH'(z_run);
    n_nx   = n_q + WIDTH'(1);
  end

  // Projection check: doubling the half-length count should
  // land within tolerance of the current count.
  always_comb begin
    cnt_w = {1'b0, cnt_nx};
    twice = {prev_q, 1'b0};
    adiff = (cnt_w >= twice) ? cnt_w - twice : twice - cnt_w;
    close = adiff <= {1'b0, tol_q};
    full  = n_nx == '1;
  end

  always_comb begin
    ckpt   = 1'b0;
    et_hit = 1'b0;
    sh     = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (n_nx == (WIDTH'(1) << j)) begin
        if (j >= ET_MIN_LOG - 1) ckpt = 1'b1;
        if (j >= ET_MIN_LOG && et_q && close) begin
          et_hit = 1'b1;
          sh     = cnt_w << (WIDTH - j);
        end
      end
    end
    et_res = sh[WIDTH] ? '1 : sh[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    et_d    = et_q;
    tol_d   = tol_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    prev_d  = prev_q;
    res_d   = res_q;
    len_d   = len_q;
    early_d = early_q;
    ov_d    = ov_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          bx_d    = bxs;
          et_d    = et_en;
          tol_d   = et_tol;
          lfsr_d  = START_STATE;
          cnt_d   = '0;
          n_d     = '0;
          prev_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          lfsr_d  = START_STATE;
          cnt_d   = '0;
          n_d     = '0;
          prev_d  = '0;
          state_d = ST_IDLE;
        end else begin
          lfsr_d = lfsr_nx;
          cnt_d  = cnt_nx;
          n_d    = n_nx;
          if (ckpt) prev_d = cnt_nx;
          if (et_hit || full) begin
            res_d   = et_hit ? et_res : cnt_nx;
            len_d   = n_nx;
            early_d = et_hit;
            ov_d    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bx_q    <= '0;
      et_q    <= 1'b0;
      tol_q   <= '0;
      lfsr_q  <= START_STATE;
      cnt_q   <= '0;
      n_q     <= '0;
      prev_q  <= '0;
      res_q   <= '0;
      len_q   <= '0;
      early_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      et_q    <= et_d;
      tol_q   <= tol_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      prev_q  <= prev_d;
      res_q   <= res_d;
      len_q   <= len_d;
      early_q <= early_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = state_q == ST_IDLE;
  assign z_valid   = state_q == ST_RUN;
  assign z         = z_valid & z_run;
  assign out_valid = ov_q;
  assign result    = res_q;
  assign out_len   = len_q;
  assign out_early = early_q;

endmodule
